// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding and default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the instruction memory (slave).
interface if_stage_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/next_pc_mux.sv
// Next-PC selection: jump target, PC-relative branch target or the sequential PC+4.
module next_pc_mux #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc4,
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [31:0]       br_offset,
  input  logic [25:0]       jaddr,
  input  logic              PCsrc,
  input  logic              jsel,
  output logic [ADDR_W-1:0] next_pc
);
  logic [31:0] off_bytes_s;

  // Pick the next fetch address; jump keeps the top nibble of the ID-stage PC+4.
  always_comb begin
    off_bytes_s = br_offset << 2;
    if (PCsrc && jsel) begin
      next_pc = {id_pc4[ADDR_W-1:28], jaddr, 2'b00};
    end else if (PCsrc) begin
      next_pc = id_pc4 + ADDR_W'($signed(off_bytes_s));
    end else begin
      next_pc = pc4;
    end
  end
endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency fetch FSM and IF/ID register.
// Optional IF_BUBBLE_CNT_EN adds a saturating count of bubbles loaded into IF/ID.
module if_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              PCsrc,
  input  logic              jsel,
  input  logic              clr,
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [31:0]       br_offset,
  input  logic [25:0]       jaddr,
  if_stage_if.master        imem,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  fetch_state_e      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              req_r;
  logic              kill_r;
  logic [31:0]       hold_r;
  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              accept_s;
  logic [31:0]       acc_instr_s;
  logic              bubble_s;

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign pc4_s          = pc_r + PC_STEP;

  next_pc_mux #(.ADDR_W(ADDR_W)) u_next_pc_mux (
    .pc4       (pc4_s),
    .id_pc4    (id_pc4),
    .br_offset (br_offset),
    .jaddr     (jaddr),
    .PCsrc     (PCsrc),
    .jsel      (jsel),
    .next_pc   (next_pc_s)
  );

  // Decide whether a word is handed to IF/ID this cycle; a redirect always drops it.
  always_comb begin
    accept_s    = 1'b0;
    acc_instr_s = imem.imem_rdata;
    case (state_r)
      WAIT: begin
        accept_s = imem.imem_ready && !kill_r && !stall && !PCsrc;
      end
      HOLD: begin
        accept_s    = !stall && !PCsrc;
        acc_instr_s = hold_r;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
    bubble_s = clr || (!stall && !accept_s);
  end

  // Fetch FSM: PC, request, wrong-path kill flag and stall hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      kill_r  <= 1'b0;
      hold_r  <= NOP_INSTR;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= WAIT;
          req_r   <= 1'b1;
          if (PCsrc) begin
            pc_r <= next_pc_s;
          end
        end
        WAIT: begin
          if (PCsrc) begin
            pc_r   <= next_pc_s;
            // Only a fetch still outstanding needs its late return discarded.
            kill_r <= !imem.imem_ready;
          end else if (imem.imem_ready) begin
            if (kill_r) begin
              kill_r <= 1'b0;
            end else if (stall) begin
              hold_r  <= imem.imem_rdata;
              state_r <= HOLD;
              req_r   <= 1'b0;
            end else begin
              pc_r <= next_pc_s;
            end
          end
        end
        HOLD: begin
          if (PCsrc || !stall) begin
            pc_r    <= next_pc_s;
            state_r <= WAIT;
            req_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall beats load, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (clr) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      ifid_valid <= ifid_valid;
    end else if (accept_s) begin
      ifid_instr <= acc_instr_s;
      ifid_pc4   <= pc4_s;
      ifid_valid <= 1'b1;
    end else begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end
  end

`ifdef IF_BUBBLE_CNT_EN
  // Saturating count of bubbles loaded into IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= 16'h0000;
    end else if (bubble_s) begin
      bubble_cnt <= sat_inc16(bubble_cnt);
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage with a combinational instruction memory.
module tb_if_stage;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic        jsel;
    logic        clr;
    logic        ready;
    logic [31:0] id_pc4;
    logic [31:0] br_off;
    logic [25:0] jaddr;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        PCsrc = 1'b0;
  logic        jsel = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] id_pc4 = 32'h0;
  logic [31:0] br_offset = 32'h0;
  logic [25:0] jaddr = 26'h0;
  logic        ready_tb = 1'b0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] cnt0;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[24];

  if_stage_if #(.ADDR_W(32)) bus ();

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  assign bus.imem_ready = ready_tb;
  assign bus.imem_rdata = word(bus.imem_addr);

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .jsel       (jsel),
    .clr        (clr),
    .id_pc4     (id_pc4),
    .br_offset  (br_offset),
    .jaddr      (jaddr),
    .imem       (bus.master),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
`ifdef IF_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic pc, input logic js, input logic cl,
                              input logic rd, input logic [31:0] ip4, input logic [31:0] bo,
                              input logic [25:0] ja, input logic [31:0] ea, input logic er,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = st; v.pcsrc = pc; v.jsel = js; v.clr = cl; v.ready = rd;
    v.id_pc4 = ip4; v.br_off = bo; v.jaddr = ja;
    v.e_addr = ea; v.e_req = er; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic pc, input logic js, input logic cl,
                       input logic rd);
    stall = st; PCsrc = pc; jsel = js; clr = cl; ready_tb = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h0,       1'b1,1'b0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h4,       1'b1,1'b1, word(32'h0), 32'h4);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h8,       1'b1,1'b1, word(32'h4), 32'h8);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h8,       1'b0,1'b1, word(32'h4), 32'h8);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h8,       1'b0,1'b1, word(32'h4), 32'h8);
    vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h8,       1'b0,1'b1, word(32'h4), 32'h8);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'hC,       1'b1,1'b1, word(32'h8), 32'hC);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h10,      1'b1,1'b1, word(32'hC), 32'h10);
    vecs[8]  = mk(1'b0,1'b1,1'b0,1'b1,1'b1, 32'h20,32'hFFFF_FFFE,26'h0, 32'h18, 1'b1,1'b0, 32'h0, 32'h0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h1C,      1'b1,1'b1, word(32'h18), 32'h1C);
    vecs[10] = mk(1'b0,1'b1,1'b1,1'b1,1'b1, 32'h1000_0004,32'h0,26'h40, 32'h1000_0100, 1'b1,1'b0, 32'h0, 32'h0);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h1000_0104, 1'b1,1'b1, word(32'h1000_0100), 32'h1000_0104);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,26'h0, 32'h1000_0104, 1'b1,1'b0, 32'h0, 32'h0);
    vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,26'h0, 32'h1000_0104, 1'b1,1'b0, 32'h0, 32'h0);
    vecs[14] = mk(1'b0,1'b1,1'b0,1'b1,1'b0, 32'h40,32'h4,26'h0, 32'h50,     1'b1,1'b0, 32'h0, 32'h0);
    vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,26'h0, 32'h50,      1'b1,1'b0, 32'h0, 32'h0);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h50,      1'b1,1'b0, 32'h0, 32'h0);
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h54,      1'b1,1'b1, word(32'h50), 32'h54);
    vecs[18] = mk(1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h54,      1'b0,1'b1, word(32'h50), 32'h54);
    vecs[19] = mk(1'b1,1'b1,1'b0,1'b0,1'b1, 32'h100,32'h0,26'h0, 32'h100,   1'b1,1'b1, word(32'h50), 32'h54);
    vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h104,     1'b1,1'b1, word(32'h100), 32'h104);
    vecs[21] = mk(1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0,26'h0, 32'h104,     1'b1,1'b0, 32'h0, 32'h0);
    vecs[22] = mk(1'b0,1'b1,1'b0,1'b0,1'b1, 32'hFFFF_FFF8,32'h1,26'h0, 32'hFFFF_FFFC, 1'b1,1'b0, 32'h0, 32'h0);
    vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0,26'h0, 32'h0,       1'b1,1'b1, word(32'hFFFF_FFFC), 32'h0);

    // Reset state
    ready_tb = 1'b1;
    tick();
    tick();
    chk("rst req",   {31'h0, bus.imem_req}, 32'h0);
    chk("rst addr",  bus.imem_addr, 32'h0);
    chk("rst valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst instr", ifid_instr, 32'h0);
    chk("rst pc4",   ifid_pc4, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].stall, vecs[i].pcsrc, vecs[i].jsel, vecs[i].clr, vecs[i].ready);
      id_pc4 = vecs[i].id_pc4;
      br_offset = vecs[i].br_off;
      jaddr = vecs[i].jaddr;
      tick();
      chk($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d req", i), {31'h0, bus.imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d instr", i), ifid_instr, vecs[i].e_instr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d pc4", i), ifid_pc4, vecs[i].e_pc4);
      end
    end

`ifdef IF_BUBBLE_CNT_EN
    // Two wait bubbles, two stalled cycles (not counted), five flushes
    cnt0 = bubble_cnt;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("bcnt after stall", {16'h0, bubble_cnt}, {16'h0, cnt0 + 16'd2});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    chk("bcnt total", {16'h0, bubble_cnt}, {16'h0, cnt0 + 16'd7});
    chk("bcnt flush valid", {31'h0, ifid_valid}, 32'h0);
`endif

    // Reset asserted mid-fetch, then a return arriving while held in reset
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid rst req",   {31'h0, bus.imem_req}, 32'h0);
    chk("mid rst addr",  bus.imem_addr, 32'h0);
    chk("mid rst valid", {31'h0, ifid_valid}, 32'h0);
    chk("mid rst instr", ifid_instr, 32'h0);
    ready_tb = 1'b1;
    tick();
    chk("rst hold valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst hold req",   {31'h0, bus.imem_req}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("restart req",   {31'h0, bus.imem_req}, 32'h1);
    chk("restart addr",  bus.imem_addr, 32'h0);
    chk("restart valid", {31'h0, ifid_valid}, 32'h0);
    tick();
    chk("restart instr", ifid_instr, word(32'h0));
    chk("restart pc4",   ifid_pc4, 32'h4);
    chk("restart addr2", bus.imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues requests to a variable-latency instruction memory, and loads the IF/ID pipeline register consumed by the decode/controller stage. It applies the controller's redirect (`PCsrc`, `jsel`) and flush (`clr`) outputs and the hazard unit's `stall`. A redirect while a fetch is in flight discards the wrong-path return.

## Interface
- `ADDR_W`, 32, PC and address width.
- `RESET_PC`, 32'h0000_0000, PC value after reset.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold PC and IF/ID (load-use hazard).
- `PCsrc`  in  1  redirect: take branch or jump target.
- `jsel`  in  1  with `PCsrc`, selects the jump target over the branch target.
- `clr`  in  1  flush IF/ID to a bubble.
- `id_pc4`  in  ADDR_W  PC+4 of the instruction currently in ID.
- `br_offset`  in  32  sign-extended branch immediate, in words.
- `jaddr`  in  26  jump target field.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address (= PC).
- `imem_ready`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `ifid_instr`  out  32  IF/ID instruction; bubble = 32'h0 (NOP).
- `ifid_pc4`  out  ADDR_W  IF/ID PC+4.
- `ifid_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Redirect target:
  - Jump, when `jsel`: {`id_pc4`[31:28], `jaddr`, 2'b00}.
  - Branch, when `PCsrc` and not `jsel`: `id_pc4` + (`br_offset` << 2), mod 2^ADDR_W.
  - Sequential: PC+4, wraps modulo 2^ADDR_W.
- FSM states and transitions:
  - IDLE: reset state. Next cycle → WAIT.
  - WAIT: `imem_req`=1. On `imem_ready`:
    - `kill`=1: discard the data, clear `kill`, stay WAIT at the current PC.
    - `stall`: capture the word in the hold buffer → HOLD.
    - Otherwise: load IF/ID, PC ← PC+4, stay WAIT, giving back-to-back requests.
  - HOLD: `imem_req`=0. When `stall` falls: load IF/ID from the hold buffer, PC ← PC+4 → WAIT.
- Redirect (`PCsrc`=1) in any state, with priority over `stall` and the sequential update:
  - PC ← target.
  - From WAIT without `imem_ready`: set `kill`.
  - From WAIT with `imem_ready`: drop the data; no `kill`.
  - From HOLD: drop the held word → WAIT.
- IF/ID update per cycle, in priority order:
  1. `clr`: bubble.
  2. `stall`: hold.
  3. Word accepted: load instruction and PC+4, valid=1.
  4. Otherwise: bubble.
- `clr` together with `stall`: `clr` wins.

## Timing
- Reset values: PC=`RESET_PC`; `imem_req`=0; `ifid_instr`=0; `ifid_pc4`=0; `ifid_valid`=0; `kill`=0; state IDLE.
- First request is issued one cycle after `rst_n` rises.
- Zero-wait memory (`imem_ready` in the same cycle as the request): one instruction per cycle; IF/ID loads at the edge that ends the request cycle.
- Redirect latency: `imem_addr` shows the target the cycle after `PCsrc`.
- The cycle after `clr`: `ifid_valid`=0 and `ifid_instr`=0.
- Reset mid-fetch: immediate return to reset values; an in-flight return is ignored.

## Configuration
- `IF_BUBBLE_CNT_EN` defined:
  - Adds output `bubble_cnt`, 16 bits, reset 0.
  - Increments on every edge where IF/ID loads a bubble (flush or memory wait; not stall).
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; the rest of the behaviour is identical.

## Structure
- Shared `mips_pkg`:
  - FSM state enum (IDLE/WAIT/HOLD).
  - `NOP_INSTR` = 32'h0.
  - Default `RESET_PC`.
- Sub-module `next_pc_mux`: combinational target selection (jump, branch, sequential), instantiated once.

## Test plan
- Reset release, `imem_ready` tied 1, `RESET_PC`=0 → `imem_addr` 0, 4, 8 on consecutive cycles; `ifid_pc4` 4, 8, 12.
- `stall` for 3 cycles while the word at 0x8 returns → HOLD, `imem_req`=0, IF/ID frozen; after release `ifid_instr`=word@0x8 and the next `imem_addr`=0xC.
- `PCsrc`=1, `id_pc4`=0x20, `br_offset`=-2 → next `imem_addr`=0x18; `clr` gives `ifid_valid`=0.
- `jsel`=1, `PCsrc`=1, `id_pc4`=0x1000_0004, `jaddr`=0x40 → `imem_addr`=0x1000_0100.
- Redirect during a 3-cycle memory wait → late return discarded, IF/ID stays a bubble, then a request goes to the target.
- With `IF_BUBBLE_CNT_EN`: 5 flush cycles plus 2 wait bubbles → `bubble_cnt`=7.
